// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and owner ids for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Owner ids double as bit indices into the two-entry grant vector.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way pick between fetch and data requests
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int PRIO_DATA = 0
) (
  input  logic       if_req,
  input  logic       d_req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (if_req && d_req) begin
      // On conflict the port that did not win last time goes, unless data is prioritised.
      if (PRIO_DATA != 0 || last_owner == OWN_IF) gnt[OWN_D] = 1'b1;
      else                                       gnt[OWN_IF] = 1'b1;
    end else if (d_req) begin
      gnt[OWN_D] = 1'b1;
    end else if (if_req) begin
      gnt[OWN_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory shared between fetch and load/store with watchdog
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_DATA = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                rsp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT);
  // The counter starts at 0 in the first WAIT cycle, so this value marks the last allowed one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          pick_gnt;

  mem_arb_pick #(
    .PRIO_DATA (PRIO_DATA)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner_q),
    .gnt        (pick_gnt)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if_gnt = pick_gnt[OWN_IF];
        d_gnt  = pick_gnt[OWN_D];
        err_d  = 1'b0;
        rdata_d = '0;
        if (pick_gnt[OWN_D]) begin
          owner_d      = OWN_D;
          last_owner_d = OWN_D;
          addr_d       = d_addr;
          we_d         = d_we;
          wdata_d      = d_wdata;
          be_d         = d_be;
          state_d      = ST_ISSUE;
        end else if (pick_gnt[OWN_IF]) begin
          owner_d      = OWN_IF;
          last_owner_d = OWN_IF;
          addr_d       = if_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          be_d         = '1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (mem_ready) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ready) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (state_q == ST_RESP) begin
      rsp_err = err_q;
      if (owner_q == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = rdata_q;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = rdata_q;
      end
    end
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      mem_en    = (state_q == ST_ISSUE);
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_be    = be_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, rsp_err;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        p_if_gnt, p_if_rvalid, p_d_gnt, p_d_rvalid, p_rsp_err;
  logic [31:0] p_if_rdata, p_d_rdata;
  logic        p_mem_en, p_mem_we;
  logic [31:0] p_mem_addr, p_mem_wdata;
  logic [3:0]  p_mem_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.PRIO_DATA(0), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.PRIO_DATA(1), .TIMEOUT(16)) dut_prio (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(p_if_gnt), .if_rvalid(p_if_rvalid), .if_rdata(p_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata), .rsp_err(p_rsp_err),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_be(p_mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("excl_gnt", {31'd0, if_gnt & d_gnt}, 32'd0);
      chk("excl_rvalid", {31'd0, if_rvalid & d_rvalid}, 32'd0);
      chk("excl_gnt_prio", {31'd0, p_if_gnt & p_d_gnt}, 32'd0);
      chk("excl_rvalid_prio", {31'd0, p_if_rvalid & p_d_rvalid}, 32'd0);
    end
  end

  initial begin
    logic exp_d;
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b1;
    tick();

    // single fetch, memory ready during ISSUE
    if_req = 1'b1; if_addr = 32'h10; #1;
    chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
    tick();
    if_req = 1'b0; if_addr = 32'hFFFF; mem_ready = 1'b1; mem_rdata = 32'h00500093; #1;
    chk("t1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    chk("t1_if_gnt_busy", {31'd0, if_gnt}, 32'd0);
    tick();
    mem_ready = 1'b0; mem_rdata = '0; #1;
    chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h00500093);
    chk("t1_err", {31'd0, rsp_err}, 32'd0);
    chk("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("t1_mem_en_resp", {31'd0, mem_en}, 32'd0);
    chk("t1_mem_addr_resp", mem_addr, 32'd0);
    tick();
    chk("t1_if_rvalid_off", {31'd0, if_rvalid}, 32'd0);

    // store with three WAIT cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'hF; #1;
    chk("t2_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0; d_wdata = '0; d_addr = '0; #1;
    chk("t2_mem_en", {31'd0, mem_en}, 32'd1);
    chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t2_mem_addr", mem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin mem_ready = 1'b1; mem_rdata = 32'h12345678; end
      #1;
      chk("t2_wait_mem_en", {31'd0, mem_en}, 32'd0);
      chk("t2_wait_mem_we", {31'd0, mem_we}, 32'd1);
      chk("t2_wait_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t2_wait_rvalid", {31'd0, d_rvalid}, 32'd0);
    end
    tick();
    mem_ready = 1'b0; #1;
    chk("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t2_d_rdata", d_rdata, 32'd0);
    chk("t2_err", {31'd0, rsp_err}, 32'd0);
    chk("t2_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("t2_mem_wdata_resp", mem_wdata, 32'd0);
    tick();
    chk("t2_d_rvalid_off", {31'd0, d_rvalid}, 32'd0);
    d_we = 1'b0;

    // conflict arbitration after a fresh reset (last_owner = IF)
    reset = 1'b0; tick(); reset = 1'b1;
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h20; d_addr = 32'h40;
    mem_ready = 1'b1; mem_rdata = 32'hA5;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      #1;
      chk("t3_rr_d_gnt", {31'd0, d_gnt}, {31'd0, exp_d});
      chk("t3_rr_if_gnt", {31'd0, if_gnt}, {31'd0, ~exp_d});
      chk("t3_prio_d_gnt", {31'd0, p_d_gnt}, 32'd1);
      chk("t3_prio_if_gnt", {31'd0, p_if_gnt}, 32'd0);
      tick();
      chk("t3_rr_mem_addr", mem_addr, exp_d ? 32'h40 : 32'h20);
      chk("t3_prio_mem_addr", p_mem_addr, 32'h40);
      tick();
      chk("t3_rr_d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d});
      chk("t3_rr_if_rvalid", {31'd0, if_rvalid}, {31'd0, ~exp_d});
      chk("t3_prio_d_rvalid", {31'd0, p_d_rvalid}, 32'd1);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;

    // watchdog abort, then a normal fetch
    if_req = 1'b1; if_addr = 32'h80; #1;
    chk("t4_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("t4_wait_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("t4_wait_mem_addr", mem_addr, 32'h80);
    end
    tick();
    chk("t4_to_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t4_to_err", {31'd0, rsp_err}, 32'd1);
    chk("t4_to_rdata", if_rdata, 32'd0);
    tick();
    if_req = 1'b1; if_addr = 32'h84; #1;
    chk("t4_next_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h13;
    tick();
    mem_ready = 1'b0; #1;
    chk("t4_next_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t4_next_rdata", if_rdata, 32'h13);
    chk("t4_next_err", {31'd0, rsp_err}, 32'd0);
    tick();

    // reset in the middle of WAIT, stray ready afterwards
    d_req = 1'b1; d_addr = 32'h200; #1;
    chk("t5_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    tick(); tick();
    reset = 1'b0; tick(); reset = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF; #1;
    chk("t5_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("t5_mem_en", {31'd0, mem_en}, 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_rdata_err", d_rdata | {31'd0, rsp_err}, 32'd0);
    tick();
    mem_ready = 1'b0; mem_rdata = '0; #1;
    chk("t5_stray_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("t5_stray_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    chk("t5_idle_mem_en", {31'd0, mem_en}, 32'd0);

    // load while fetch request toggles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; #1;
    chk("t6_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0; if_req = 1'b1; #1;
    chk("t6_if_gnt_issue", {31'd0, if_gnt}, 32'd0);
    tick();
    if_req = 1'b0; #1;
    chk("t6_if_gnt_wait", {31'd0, if_gnt}, 32'd0);
    tick();
    if_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h77; #1;
    chk("t6_if_gnt_wait2", {31'd0, if_gnt}, 32'd0);
    tick();
    mem_ready = 1'b0; #1;
    chk("t6_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t6_d_rdata", d_rdata, 32'h77);
    chk("t6_if_gnt_resp", {31'd0, if_gnt}, 32'd0);
    tick();
    chk("t6_if_gnt_idle", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h99;
    tick();
    mem_ready = 1'b0; #1;
    chk("t6_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t6_if_rdata", if_rdata, 32'h99);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
